// File: rtl/mesh_check_pkg.sv
// rtl/mesh_check_pkg.sv - shared types and constants for the mesh result checker
package mesh_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_REVERSE  = 2'd0;
  localparam logic [1:0] MODE_IDENTITY = 2'd1;
  localparam logic [1:0] MODE_ASCEND   = 2'd2;
  localparam logic [1:0] MODE_FLAGADDR = 2'd3;

  // Entry layout is {flag, addr, data} with data in the low bits.
  function automatic int addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int flag_pos(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/mesh_check_entry.sv
// rtl/mesh_check_entry.sv - combinational per-PE comparator against the selected pattern
module mesh_check_entry
  import mesh_check_pkg::*;
#(
  parameter int N          = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ENTRY_W    = ADDR_WIDTH + DATA_WIDTH + 1
) (
  input  logic [ENTRY_W-1:0]    entry,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] prev_data,
  input  logic                  first,
  output logic                  mismatch
);

  localparam int ALSB = addr_lsb(DATA_WIDTH);
  localparam int FPOS = flag_pos(ADDR_WIDTH, DATA_WIDTH);

  logic                  flag;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] exp_id;
  logic [DATA_WIDTH-1:0] exp_rev;
  logic                  data_bad;

  assign flag    = entry[FPOS];
  assign addr    = entry[ALSB +: ADDR_WIDTH];
  assign data    = entry[DATA_WIDTH-1:0];
  assign exp_id  = DATA_WIDTH'(idx);
  assign exp_rev = DATA_WIDTH'(N - 1) - exp_id;

  always_comb begin
    data_bad = 1'b0;
    case (mode)
      MODE_REVERSE:  data_bad = (data != exp_rev);
      MODE_IDENTITY: data_bad = (data != exp_id);
      MODE_ASCEND:   data_bad = !first && (data < prev_data);
      default:       data_bad = 1'b0;
    endcase
  end

  assign mismatch = flag | (addr != idx) | data_bad;

endmodule

// File: rtl/mesh_result_checker.sv
// rtl/mesh_result_checker.sv - settle, scan and verdict FSM over the mesh PE result words
module mesh_result_checker
  import mesh_check_pkg::*;
#(
  parameter int N           = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 80,
  parameter int ENTRY_W     = ADDR_WIDTH + DATA_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [N*ENTRY_W-1:0]   results,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N-1:0]           err_mask,
  output logic                   first_err_vld,
  output logic [ADDR_WIDTH-1:0]  first_err_idx
);

  localparam int                    CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]         WAIT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(N - 1);
  localparam logic [N-1:0]          ONE_HOT0  = N'(1);

  state_t                state;
  logic [CW-1:0]         wait_cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] prev_data;
  logic [ENTRY_W-1:0]    cur_entry;
  logic                  mismatch;
  logic [N-1:0]          err_mask_nxt;

  assign cur_entry    = results[int'(idx)*ENTRY_W +: ENTRY_W];
  assign err_mask_nxt = err_mask | (mismatch ? (ONE_HOT0 << idx) : '0);

  mesh_check_entry #(
    .N          (N),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRY_W    (ENTRY_W)
  ) u_entry (
    .entry     (cur_entry),
    .idx       (idx),
    .mode      (mode_q),
    .prev_data (prev_data),
    .first     (idx == '0),
    .mismatch  (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      idx           <= '0;
      mode_q        <= MODE_REVERSE;
      prev_data     <= '0;
      pass          <= 1'b0;
      err_mask      <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q        <= mode;
            pass          <= 1'b0;
            err_mask      <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            wait_cnt      <= WAIT_LOAD;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            idx   <= '0;
            state <= ST_SCAN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_SCAN: begin
          prev_data <= cur_entry[DATA_WIDTH-1:0];
          err_mask  <= err_mask_nxt;
          if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= idx;
          end
          // Verdict includes the last PE, whose mask bit lands on this same edge.
          if (idx == LAST_IDX) begin
            pass  <= ~|err_mask_nxt;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_WAIT) || (state == ST_SCAN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mesh_result_checker.sv
// tb/tb_mesh_result_checker.sv - scoreboard bench for mesh_result_checker
module tb_mesh_result_checker;

  localparam int N_A = 16, AW_A = 4, W_A = 80, EW_A = 37;
  localparam int N_B = 4,  AW_B = 2, W_B = 1,  EW_B = 35;

  typedef struct {
    string       tag;
    logic        pass;
    logic [15:0] mask;
    logic        vld;
    logic [3:0]  idx;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [N_A*EW_A-1:0] results_a = '0;
  logic [N_B*EW_B-1:0] results_b = '0;

  logic busy_a, done_a, pass_a, vld_a;
  logic [N_A-1:0]  mask_a;
  logic [AW_A-1:0] idx_a;
  logic busy_b, done_b, pass_b, vld_b;
  logic [N_B-1:0]  mask_b;
  logic [AW_B-1:0] idx_b;

  always #5 clk = ~clk;

  mesh_result_checker #(.N(N_A), .ADDR_WIDTH(AW_A), .DATA_WIDTH(32), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .results(results_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_mask(mask_a),
    .first_err_vld(vld_a), .first_err_idx(idx_a)
  );

  mesh_result_checker #(.N(N_B), .ADDR_WIDTH(AW_B), .DATA_WIDTH(32), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .results(results_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_mask(mask_b),
    .first_err_vld(vld_b), .first_err_idx(idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int k, input logic f, input logic [3:0] a, input logic [31:0] d);
    results_a[k*EW_A +: EW_A] = {f, a, d};
  endtask

  task automatic set_b(input int k, input logic f, input logic [1:0] a, input logic [31:0] d);
    results_b[k*EW_B +: EW_B] = {f, a, d};
  endtask

  // kind 0: reverse (N-1-k), 1: identity (k), 2: ascending {1,1,2,...}
  task automatic pat_a(input int kind);
    for (int k = 0; k < N_A; k++)
      set_a(k, 1'b0, 4'(k), (kind == 0) ? 32'(N_A - 1 - k) : (kind == 1) ? 32'(k) : ((k == 0) ? 32'd1 : 32'(k)));
  endtask

  task automatic drive_start(input int which, input logic v);
    if (which == 1) start_b = v;
    else            start_a = v;
  endtask

  task automatic run_check(input int which, input logic [1:0] m, input string tag,
                           input logic ep, input logic [15:0] em, input logic ev, input logic [3:0] ei,
                           input bit rs_wait, input bit rs_done);
    exp_t e;
    int   n;
    bit   got;
    int   lat;
    int   extra;
    lat = (which == 1) ? (W_B + N_B + 1) : (W_A + N_A + 1);
    sb.push_back('{tag, ep, em, ev, ei, lat});
    @(negedge clk);
    drive_start(which, 1'b1);
    mode = m;
    n = 0;
    got = 0;
    while (!got && n < lat + 10) begin
      @(negedge clk);
      n++;
      drive_start(which, rs_wait && (n == 5));
      if (n == 1) chk({tag, "/busy_after_start"}, (which == 1) ? busy_b : busy_a, 1);
      if ((which == 1) ? done_b : done_a) got = 1;
    end
    e = sb.pop_front();
    chk({e.tag, "/done_seen"}, 32'(got), 1);
    if (got) begin
      chk({e.tag, "/latency"}, n, e.lat);
      chk({e.tag, "/busy_in_done"}, (which == 1) ? busy_b : busy_a, 0);
      chk({e.tag, "/pass"}, (which == 1) ? pass_b : pass_a, e.pass);
      chk({e.tag, "/err_mask"}, (which == 1) ? {12'b0, mask_b} : mask_a, e.mask);
      chk({e.tag, "/first_err_vld"}, (which == 1) ? vld_b : vld_a, e.vld);
      chk({e.tag, "/first_err_idx"}, (which == 1) ? {2'b0, idx_b} : idx_a, e.idx);
    end
    drive_start(which, rs_done);
    @(negedge clk);
    drive_start(which, 1'b0);
    chk({tag, "/done_single_pulse"}, (which == 1) ? done_b : done_a, 0);
    chk({tag, "/pass_held"}, (which == 1) ? pass_b : pass_a, ep);
    if (rs_done) begin
      extra = 0;
      repeat (lat + 4) begin
        @(negedge clk);
        if ((which == 1) ? done_b : done_a) extra++;
      end
      chk({tag, "/no_done_after_ignored_start"}, extra, 0);
    end
  endtask

  initial begin : main
    int n;
    int extra;
    repeat (3) @(negedge clk);
    chk("reset/busy", busy_a, 0);
    chk("reset/done", done_a, 0);
    chk("reset/pass", pass_a, 0);
    chk("reset/err_mask", mask_a, 0);
    chk("reset/first_err_vld", vld_a, 0);
    chk("reset/first_err_idx", idx_a, 0);
    chk("reset/b_busy", busy_b, 0);
    chk("reset/b_done", done_b, 0);
    rst_n = 1'b1;

    pat_a(0);
    run_check(0, 2'd0, "rev", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b1);
    set_a(5, 1'b0, 4'd5, 32'hAA);
    set_a(9, 1'b1, 4'd9, 32'd6);
    run_check(0, 2'd0, "rev_err", 1'b0, 16'h0220, 1'b1, 4'd5, 1'b0, 1'b0);

    pat_a(1);
    run_check(0, 2'd1, "ident", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    run_check(0, 2'd0, "ident_as_rev", 1'b0, 16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b0);

    pat_a(2);
    run_check(0, 2'd2, "ascend", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    set_a(8, 1'b0, 4'd8, 32'd0);
    run_check(0, 2'd2, "ascend_dip", 1'b0, 16'h0100, 1'b1, 4'd8, 1'b0, 1'b0);

    for (int k = 0; k < N_A; k++) set_a(k, 1'b0, 4'(k), $urandom);
    run_check(0, 2'd3, "flagaddr", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    set_a(3, 1'b0, 4'd12, 32'd3);
    run_check(0, 2'd3, "flagaddr_bad", 1'b0, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0);

    // Reset while PE 7 is being scanned with a failing pattern.
    pat_a(1);
    @(negedge clk);
    start_a = 1'b1;
    mode = 2'd0;
    n = 0;
    while (n < W_A + 1 + 7) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
    end
    chk("midscan/busy", busy_a, 1);
    chk("midscan/first_err_vld", vld_a, 1);
    chk("midscan/err_mask", mask_a, 16'h007F);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midscan_rst/busy", busy_a, 0);
    chk("midscan_rst/done", done_a, 0);
    chk("midscan_rst/pass", pass_a, 0);
    chk("midscan_rst/err_mask", mask_a, 0);
    chk("midscan_rst/first_err_vld", vld_a, 0);
    chk("midscan_rst/first_err_idx", idx_a, 0);
    rst_n = 1'b1;
    extra = 0;
    repeat (W_A + N_A + 4) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    chk("midscan_rst/no_done", extra, 0);
    run_check(0, 2'd1, "after_rst", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);

    for (int k = 0; k < N_B; k++) set_b(k, 1'b0, 2'(k), 32'(N_B - 1 - k));
    run_check(1, 2'd0, "b_rev", 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1);
    set_b(3, 1'b1, 2'd3, 32'd0);
    run_check(1, 2'd0, "b_flag", 1'b0, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesh_result_checker.md
# mesh_result_checker

Synthesizable, parametrised self-checking monitor for the sorting mesh. After a `start` pulse it waits a programmable settle time for the mesh to finish sorting, then scans the N PE `nanci_result` words one per cycle against a selectable expected pattern. It reports pass/fail, a per-PE mismatch mask and the first failing index. It sits beside `mesh` in benches and on FPGA builds, replacing hand-written per-N checks with one block that works for any N, width or pattern.

## Interface
- `N`, 16: number of PEs (≥2)
- `ADDR_WIDTH`, 4: address field width; N ≤ 2^ADDR_WIDTH
- `DATA_WIDTH`, 32: data field width
- `WAIT_CYCLES`, 80: settle cycles between start and scan (≥1)
- `ENTRY_W`, ADDR_WIDTH+DATA_WIDTH+1: derived per-PE result width {flag, addr, data}
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a check
- `mode`  in  2  expected pattern, latched on accepted start
- `results`  in  N*ENTRY_W  flattened PE results; PE k occupies bits [k*ENTRY_W +: ENTRY_W]
- `busy`  out  1  high in WAIT and SCAN
- `done`  out  1  one-cycle pulse when the verdict is final
- `pass`  out  1  verdict, held until the next accepted start
- `err_mask`  out  N  bit k set if PE k mismatched
- `first_err_vld`  out  1  at least one mismatch recorded
- `first_err_idx`  out  ADDR_WIDTH  lowest failing PE index

## Operation
- States: IDLE → WAIT → SCAN → DONE → IDLE.
- IDLE: `start`=1 is accepted. It latches `mode`, clears `err_mask`, `first_err_*` and `pass`, loads the wait counter with WAIT_CYCLES-1 and moves to WAIT.
- WAIT: the counter decrements. At 0 the FSM moves to SCAN with index k=0.
- SCAN: PE k is checked in each cycle, sampling `results` live. On a mismatch, `err_mask[k]` is set; if `first_err_vld`=0, `first_err_idx`=k and `first_err_vld`=1. After k=N-1 the FSM moves to DONE.
- DONE: one cycle. `done`=1 and `pass`=~|err_mask. The FSM then returns to IDLE.
- Per-PE check for all modes: flag bit must be 0 and addr field must equal k[ADDR_WIDTH-1:0].
- Mode 0, reverse: data must equal N-1-k, zero-extended to DATA_WIDTH.
- Mode 1, identity: data must equal k.
- Mode 2, ascending: for k≥1, data[k] ≥ data[k-1] unsigned, using a previous-data register loaded during SCAN. k=0 gets the flag/addr check only.
- Mode 3, flag/addr only: data is ignored.
- `start` while busy or in DONE is ignored. It does not restart and is not queued.
- `rst_n` low at any time, including mid-WAIT or mid-SCAN, returns the FSM to IDLE and clears all outputs. Partial results are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `first_err_vld`=0, `first_err_idx`=0.
- Start accepted at edge t. `busy` is high from t+1.
- WAIT occupies cycles t+1 … t+WAIT_CYCLES.
- SCAN occupies the next N cycles.
- `done` pulses at t+WAIT_CYCLES+N+1. `busy` is low in that cycle.
- Total start-to-done latency is WAIT_CYCLES+N+1 cycles.
- `err_mask`/`first_err_*` update in the cycle after each PE is checked. They are final when `done`=1 and stable until the next accepted start.
- The earliest re-start is accepted in the cycle after `done`.

## Structure
- Package `mesh_check_pkg`:
  - state enum {IDLE, WAIT, SCAN, DONE}
  - mode constants MODE_REVERSE=0, MODE_IDENTITY=1, MODE_ASCEND=2, MODE_FLAGADDR=3
  - entry field offset helpers
- Sub-module `mesh_check_entry`: combinational comparator. Inputs are the entry, k, mode, previous data and a first-entry flag. Output is a mismatch bit. The top level holds the FSM, counters, index mux and result registers.

## Test plan
- N=16, mesh sorting input 15…0, mode 0, start at cycle 3 → `done` at cycle 3+80+17=100, `pass`=1, `err_mask`=0, `first_err_vld`=0.
- Same run, PE 5 data forced to 0xAA and PE 9 flag forced to 1 → `pass`=0, `err_mask`=16'h0220, `first_err_idx`=5.
- Static results with data=k at every PE, mode 1 → pass. Same results in mode 0 → `err_mask`=16'hFFFF, first idx 0.
- Mode 2 with data {1,1,2,…,15}, then with PE 8 data=0 → first run passes. Second run: `err_mask`=16'h0100.
- `rst_n` low for 2 cycles mid-SCAN (k=7) → all outputs 0, no `done`. A new start then completes normally with pass.
- `start` re-pulsed during WAIT and in DONE → ignored, single `done` pulse, latency unchanged. N=4, WAIT_CYCLES=1 corner → `done` 6 cycles after start.
